// File: rtl/uart_pkg.sv
// Shared UART definitions: the frame FSM state encoding (also used by the
// receiver) and the parity sense constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DBIT data bits, optional parity, OS ticks per
// bit, SB_TICK ticks of stop, with a one-entry holding register for gapless frames.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int OS         = 16,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic [DBIT-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic [2:0]      dbg_state
);

  localparam int SW = $clog2((OS > SB_TICK) ? OS : SB_TICK);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] OS_LAST = SW'(OS - 1);
  localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);
  localparam logic PAR_SENSE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  if (DBIT < 5 || DBIT > 9) begin : g_bad_dbit
    $error("uart_tx_cfg: DBIT must be 5..9");
  end
  if (OS != 8 && OS != 16) begin : g_bad_os
    $error("uart_tx_cfg: OS must be 8 or 16");
  end
  if (SB_TICK != OS && 2 * SB_TICK != 3 * OS && SB_TICK != 2 * OS) begin : g_bad_sb
    $error("uart_tx_cfg: SB_TICK must be OS, 1.5*OS or 2*OS");
  end

  uart_state_e     state_q, state_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [DBIT-1:0] hold_data_q, hold_data_d;
  logic            par_q, par_d;
  logic            hold_par_q, hold_par_d;
  logic            hold_full_q, hold_full_d;
  logic            tx_q, tx_d;
  logic            load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      s_cnt_q     <= '0;
      n_cnt_q     <= '0;
      shreg_q     <= '0;
      hold_data_q <= '0;
      par_q       <= 1'b0;
      hold_par_q  <= 1'b0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      n_cnt_q     <= n_cnt_d;
      shreg_q     <= shreg_d;
      hold_data_q <= hold_data_d;
      par_q       <= par_d;
      hold_par_q  <= hold_par_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    s_cnt_d     = s_cnt_q;
    n_cnt_d     = n_cnt_q;
    shreg_d     = shreg_q;
    hold_data_d = hold_data_q;
    par_d       = par_q;
    hold_par_d  = hold_par_q;
    hold_full_d = hold_full_q;
    tx_d        = tx_q;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        load = hold_full_q;
      end
      START: if (s_tick) begin
        if (s_cnt_q == OS_LAST) begin
          s_cnt_d = '0;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          n_cnt_d = '0;
          state_d = DATA;
        end else begin
          s_cnt_d = s_cnt_q + SW'(1);
        end
      end
      DATA: if (s_tick) begin
        if (s_cnt_q == OS_LAST) begin
          s_cnt_d = '0;
          if (n_cnt_q == N_LAST) begin
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            n_cnt_d = n_cnt_q + NW'(1);
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end else begin
          s_cnt_d = s_cnt_q + SW'(1);
        end
      end
      PARITY: if (s_tick) begin
        if (s_cnt_q == OS_LAST) begin
          s_cnt_d = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          s_cnt_d = s_cnt_q + SW'(1);
        end
      end
      STOP: if (s_tick) begin
        if (s_cnt_q == SB_LAST) begin
          s_cnt_d = '0;
          load    = hold_full_q;
          state_d = IDLE;
        end else begin
          s_cnt_d = s_cnt_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A load overrides the state decision so the next start bit follows the
    // stop period (or the idle cycle) on the very same edge.
    if (load) begin
      shreg_d     = hold_data_q;
      par_d       = hold_par_q;
      hold_full_d = 1'b0;
      s_cnt_d     = '0;
      n_cnt_d     = '0;
      tx_d        = 1'b0;
      state_d     = START;
    end

    // Handshake: a word transfers on a clk edge where tx_valid and tx_ready
    // are both high; tx_ready is the registered inverse of hold_full, so a
    // word being loaded and a new word being accepted never share an edge.
    if (tx_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data;
      hold_par_d  = (^tx_data) ^ PAR_SENSE;
    end
  end

  always_comb begin
    tx           = tx_q;
    tx_ready     = !hold_full_q;
    tx_busy      = (state_q != IDLE);
    tx_done_tick = (state_q == STOP) && s_tick && (s_cnt_q == SB_LAST);
    dbg_state    = state_q;
  end

endmodule
